// File: rtl/mem_pkg.sv
// Shared definitions for the mirrored RAM: controller state encoding and
// the set of supported read latencies.
package mem_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_e;

   localparam int READ_LAT_MIN = 1;
   localparam int READ_LAT_MAX = 2;

   function automatic bit read_lat_legal(input int lat);
      return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
   endfunction

endpackage

// File: rtl/ram_sp_core.sv
// Single-port synchronous RAM with write enable and a registered read port.
// The read register holds its value until the next read; the array has no reset.
module ram_sp_core #(
   parameter int DEPTH_LOG2 = 11,
   parameter int DATA_W     = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic                  re,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [DATA_W-1:0]     wdata,
   output logic [DATA_W-1:0]     rdata
);

   logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem_q[addr];
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/mirrored_ram.sv
// Mirrored bus RAM: low address bits index the array, upper bits alias.
// After reset an optional sweep fills the array before accesses are accepted.
//
//   state | meaning
//   CLEAR | sweep writes FILL_VALUE to clr_idx each cycle, ready=0
//   IDLE  | bus reads/writes accepted, ready=1
module mirrored_ram
   import mem_pkg::*;
#(
   parameter int ADDR_W         = 16,
   parameter int DEPTH_LOG2     = 11,
   parameter int DATA_W         = 8,
   parameter int READ_LAT       = 1,
   parameter int ROM_MODE       = 0,
   parameter int CLEAR_ON_RESET = 1,
   parameter int FILL_VALUE     = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   inout  wire  [DATA_W-1:0] data,
   input  logic              rw_n,
   input  logic              cs_n,
   output logic              ready,
   output logic              rd_valid
);

   localparam logic [DEPTH_LOG2-1:0] LAST_IDX = {DEPTH_LOG2{1'b1}};
   localparam logic [DATA_W-1:0]     FILL     = DATA_W'(FILL_VALUE);
   localparam state_e                RST_ST   = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

   if (!read_lat_legal(READ_LAT)) begin : g_bad_lat
      $error("mirrored_ram: READ_LAT must be 1 or 2");
   end

   state_e                state_q,   state_d;
   logic [DEPTH_LOG2-1:0] clr_idx_q, clr_idx_d;
   logic                  vld1_q,    vld1_d;
   logic                  vld2_q,    vld2_d;
   logic [DATA_W-1:0]     stage2_q,  stage2_d;

   logic                  bus_rd;
   logic                  core_we;
   logic [DEPTH_LOG2-1:0] core_addr;
   logic [DATA_W-1:0]     core_wdata;
   logic [DATA_W-1:0]     core_rdata;
   logic [DATA_W-1:0]     out_data;
   logic                  unused_addr_hi;

   assign unused_addr_hi = ^addr[ADDR_W-1:DEPTH_LOG2];

   always_comb begin
      state_d    = state_q;
      clr_idx_d  = clr_idx_q;
      bus_rd     = 1'b0;
      core_we    = 1'b0;
      core_addr  = addr[DEPTH_LOG2-1:0];
      core_wdata = data;
      unique case (state_q)
         CLEAR: begin
            core_we    = 1'b1;
            core_addr  = clr_idx_q;
            core_wdata = FILL;
            // hold on the last index once written; the sweep never wraps
            if (clr_idx_q == LAST_IDX) begin
               state_d = IDLE;
            end else begin
               clr_idx_d = clr_idx_q + 1'b1;
            end
         end
         IDLE: begin
            bus_rd  = !cs_n && rw_n;
            core_we = !cs_n && !rw_n && (ROM_MODE == 0);
         end
      endcase
      if (rst) begin
         bus_rd  = 1'b0;
         core_we = 1'b0;
      end
   end

   always_comb begin
      vld1_d   = bus_rd;
      vld2_d   = vld1_q;
      stage2_d = core_rdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RST_ST;
         clr_idx_q <= '0;
         vld1_q    <= 1'b0;
         vld2_q    <= 1'b0;
         stage2_q  <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         vld1_q    <= vld1_d;
         vld2_q    <= vld2_d;
         stage2_q  <= stage2_d;
      end
   end

   ram_sp_core #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .DATA_W     (DATA_W)
   ) u_core (
      .clk   (clk),
      .rst   (rst),
      .we    (core_we),
      .re    (bus_rd),
      .addr  (core_addr),
      .wdata (core_wdata),
      .rdata (core_rdata)
   );

   assign out_data = (READ_LAT == 2) ? stage2_q : core_rdata;
   assign rd_valid = (READ_LAT == 2) ? vld2_q : vld1_q;
   assign ready    = (state_q == IDLE);
   assign data     = (!cs_n && rw_n && ready) ? out_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mirrored_ram.sv
// Bench for mirrored_ram: four parameter variants share one stimulus stream and
// are checked every cycle against an array/scoreboard model of the bus RAM.
module tb_mirrored_ram;

   localparam int N     = 4;
   localparam int DEPTH = 2048;
   localparam int         LAT  [N] = '{1, 2, 1, 1};
   localparam bit         ROM  [N] = '{1'b0, 1'b0, 1'b1, 1'b0};
   localparam bit         COR  [N] = '{1'b1, 1'b1, 1'b1, 1'b0};
   localparam logic [7:0] FILL [N] = '{8'h00, 8'h00, 8'h5A, 8'h00};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cs_n = 1'b1;
   logic        rw_n = 1'b1;
   logic        tb_en = 1'b0;
   logic [15:0] addr = '0;
   logic [7:0]  drv = '0;

   tri1 [7:0] bus0, bus1, bus2, bus3;
   wire [7:0] bus_v [N];
   wire [N-1:0] ready_w;
   wire [N-1:0] vld_w;

   assign bus0 = tb_en ? drv : 8'hzz;
   assign bus1 = tb_en ? drv : 8'hzz;
   assign bus2 = tb_en ? drv : 8'hzz;
   assign bus3 = tb_en ? drv : 8'hzz;
   assign bus_v[0] = bus0;
   assign bus_v[1] = bus1;
   assign bus_v[2] = bus2;
   assign bus_v[3] = bus3;

   always #5 clk = ~clk;

   mirrored_ram u_d0 (
      .clk(clk), .rst(rst), .addr(addr), .data(bus0), .rw_n(rw_n), .cs_n(cs_n),
      .ready(ready_w[0]), .rd_valid(vld_w[0]));
   mirrored_ram #(.READ_LAT(2)) u_d1 (
      .clk(clk), .rst(rst), .addr(addr), .data(bus1), .rw_n(rw_n), .cs_n(cs_n),
      .ready(ready_w[1]), .rd_valid(vld_w[1]));
   mirrored_ram #(.ROM_MODE(1), .FILL_VALUE(8'h5A)) u_d2 (
      .clk(clk), .rst(rst), .addr(addr), .data(bus2), .rw_n(rw_n), .cs_n(cs_n),
      .ready(ready_w[2]), .rd_valid(vld_w[2]));
   mirrored_ram #(.CLEAR_ON_RESET(0)) u_d3 (
      .clk(clk), .rst(rst), .addr(addr), .data(bus3), .rw_n(rw_n), .cs_n(cs_n),
      .ready(ready_w[3]), .rd_valid(vld_w[3]));

   // reference model: memory image, remaining sweep writes, and reads keyed by accept cycle
   logic [7:0] m_mem   [N][DEPTH];
   bit         m_known [N][DEPTH];
   int         m_left  [N];
   logic [7:0] m_out   [N];
   bit         m_out_k [N];
   bit         acc_v   [N][8];
   bit         acc_k   [N][8];
   logic [7:0] acc_d   [N][8];
   int         cyc = 0;
   bit         mon_en = 1'b0;
   int         n_cmp = 0;
   int         n_fail = 0;

   task automatic model_step();
      int s, d, ix;
      cyc++;
      s  = cyc % 8;
      ix = int'(addr) % DEPTH;
      for (int i = 0; i < N; i++) begin
         if (rst) begin
            m_left[i]  = COR[i] ? DEPTH : 0;
            m_out[i]   = 8'h00;
            m_out_k[i] = 1'b1;
            for (int k = 0; k < 8; k++) acc_v[i][k] = 1'b0;
         end else begin
            acc_v[i][s] = 1'b0;
            if (m_left[i] > 0) begin
               m_mem[i][DEPTH - m_left[i]]   = FILL[i];
               m_known[i][DEPTH - m_left[i]] = 1'b1;
               m_left[i]--;
            end else if (!cs_n) begin
               if (!rw_n) begin
                  if (!ROM[i]) begin
                     m_mem[i][ix]   = drv;
                     m_known[i][ix] = 1'b1;
                  end
               end else begin
                  acc_v[i][s] = 1'b1;
                  acc_d[i][s] = m_mem[i][ix];
                  acc_k[i][s] = m_known[i][ix];
               end
            end
            d = (cyc - LAT[i] + 1) % 8;
            if (acc_v[i][d]) begin
               m_out[i]   = acc_d[i][d];
               m_out_k[i] = acc_k[i][d];
            end
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      #2;
   endtask

   task automatic access(input bit r, input bit c, input bit w,
                         input logic [15:0] a, input logic [7:0] d);
      rst   = r;
      cs_n  = c;
      rw_n  = w;
      addr  = a;
      drv   = d;
      tb_en = !w;
      cycle();
   endtask

   logic [7:0] mon_bus;
   bit         mon_chk, mon_rdy, mon_vld;
   always @(negedge clk) begin
      if (mon_en) begin
         for (int i = 0; i < N; i++) begin
            mon_rdy = (m_left[i] == 0);
            mon_vld = acc_v[i][(cyc - LAT[i] + 1) % 8];
            n_cmp++;
            if (ready_w[i] !== mon_rdy) begin
               n_fail++;
               $display("FAIL mon_ready[%0d] cyc %0d: got %b want %b", i, cyc, ready_w[i], mon_rdy);
            end
            n_cmp++;
            if (vld_w[i] !== mon_vld) begin
               n_fail++;
               $display("FAIL mon_rd_valid[%0d] cyc %0d: got %b want %b", i, cyc, vld_w[i], mon_vld);
            end
            mon_chk = 1'b1;
            if (tb_en) begin
               mon_bus = drv;
            end else if (!cs_n && rw_n && mon_rdy) begin
               mon_bus = m_out[i];
               mon_chk = m_out_k[i];
            end else begin
               mon_bus = 8'hFF;   // released bus reads as the pull-up value
            end
            if (mon_chk) begin
               n_cmp++;
               if (bus_v[i] !== mon_bus) begin
                  n_fail++;
                  $display("FAIL mon_data[%0d] cyc %0d: got %h want %h", i, cyc, bus_v[i], mon_bus);
               end
            end
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (ready_w !== 4'hF && n < 3000) begin
         access(0, 1, 1, 16'h0000, 8'h00);
         n++;
      end
      n_cmp++;
      if (ready_w !== 4'hF) begin
         n_fail++;
         $display("FAIL wait_ready: got %b want 1111 after %0d cycles", ready_w, n);
      end
   endtask

   task automatic test_reset();
      mon_en = 1'b1;
      access(1, 1, 1, 16'h0000, 8'h00);
      n_cmp++;
      if (ready_w[0] !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready0: got %b want 0", ready_w[0]);
      end
      n_cmp++;
      if (vld_w !== 4'h0) begin
         n_fail++; $display("FAIL reset_rd_valid: got %b want 0000", vld_w);
      end
      access(0, 1, 1, 16'h0000, 8'h00);
      n_cmp++;
      if (ready_w[3] !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready_noclear: got %b want 1", ready_w[3]);
      end
   endtask

   task automatic test_clear_sweep();
      int cnt, n;
      logic [15:0] ra [3];
      ra[0] = 16'h0000; ra[1] = 16'h03FF; ra[2] = 16'h07FF;
      access(1, 1, 1, 16'h0000, 8'h00);
      cnt = (ready_w[0] === 1'b0) ? 1 : 0;
      n = 0;
      while (n < 4000) begin
         access(0, 1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom));
         n++;
         if (ready_w[0] === 1'b0) cnt++;
         else break;
      end
      n_cmp++;
      if (cnt !== 2048) begin
         n_fail++; $display("FAIL sweep_len: got %0d want 2048", cnt);
      end
      wait_ready();
      for (int k = 0; k < 3; k++) begin
         access(0, 0, 1, ra[k], 8'h00);
         n_cmp++;
         if (vld_w[0] !== 1'b1 || bus0 !== 8'h00) begin
            n_fail++;
            $display("FAIL sweep_read %h: got valid %b data %h want 1 00", ra[k], vld_w[0], bus0);
         end
      end
   endtask

   task automatic test_mirror();
      access(0, 0, 0, 16'h0012, 8'hA5);
      access(0, 0, 1, 16'h1812, 8'h00);
      n_cmp++;
      if (vld_w[0] !== 1'b1 || bus0 !== 8'hA5) begin
         n_fail++; $display("FAIL mirror_1812: got valid %b data %h want 1 a5", vld_w[0], bus0);
      end
      access(0, 0, 0, 16'h1007, 8'h3C);
      access(0, 0, 1, 16'h0807, 8'h00);
      n_cmp++;
      if (bus0 !== 8'h3C) begin
         n_fail++; $display("FAIL mirror_0807: got %h want 3c", bus0);
      end
   endtask

   task automatic test_latency();
      logic [7:0]  want [3];
      logic [15:0] ra   [5];
      int hits, first;
      want[0] = 8'h11; want[1] = 8'h22; want[2] = 8'h33;
      ra[0] = 16'h1; ra[1] = 16'h2; ra[2] = 16'h3; ra[3] = 16'h4; ra[4] = 16'h4;
      for (int k = 0; k < 3; k++) access(0, 0, 0, 16'(k + 1), want[k]);
      for (int j = 0; j < 5; j++) begin
         access(0, 0, 1, ra[j], 8'h00);
         n_cmp++;
         if (vld_w[1] !== 1'(j >= 1)) begin
            n_fail++; $display("FAIL lat2_valid j%0d: got %b want %b", j, vld_w[1], (j >= 1));
         end
         if (j >= 1 && j <= 3) begin
            n_cmp++;
            if (bus1 !== want[j-1]) begin
               n_fail++; $display("FAIL lat2_data j%0d: got %h want %h", j, bus1, want[j-1]);
            end
         end
      end
      access(0, 1, 1, 16'h0000, 8'h00);
      access(0, 1, 1, 16'h0000, 8'h00);
      hits  = 0;
      first = -1;
      for (int j = 0; j < 8; j++) begin
         if (j < 3) access(0, 0, 1, 16'(j + 1), 8'h00);
         else       access(0, 1, 1, 16'h0000, 8'h00);
         if (vld_w[1] === 1'b1) begin
            hits++;
            if (first < 0) first = j;
         end
      end
      n_cmp++;
      if (hits !== 3 || first !== 1) begin
         n_fail++; $display("FAIL lat2_pulses: got %0d from %0d want 3 from 1", hits, first);
      end
   endtask

   task automatic test_rom();
      access(0, 0, 0, 16'h0005, 8'hFF);
      access(0, 0, 1, 16'h0005, 8'h00);
      n_cmp++;
      if (bus2 !== 8'h5A) begin
         n_fail++; $display("FAIL rom_read: got %h want 5a", bus2);
      end
      n_cmp++;
      if (bus0 !== 8'hFF) begin
         n_fail++; $display("FAIL ram_read: got %h want ff", bus0);
      end
   endtask

   task automatic test_reset_mid();
      int cnt, n;
      access(1, 1, 1, 16'h0000, 8'h00);
      for (int k = 0; k < 1000; k++) access(0, 1, 1, 16'h0000, 8'h00);
      n_cmp++;
      if (ready_w[0] !== 1'b0) begin
         n_fail++; $display("FAIL mid_sweep_ready: got %b want 0", ready_w[0]);
      end
      access(1, 1, 1, 16'h0000, 8'h00);
      cnt = (ready_w[0] === 1'b0) ? 1 : 0;
      n = 0;
      while (n < 4000) begin
         access(0, 1, 1, 16'h0000, 8'h00);
         n++;
         if (ready_w[0] === 1'b0) cnt++;
         else break;
      end
      n_cmp++;
      if (cnt !== 2048) begin
         n_fail++; $display("FAIL restart_len: got %0d want 2048", cnt);
      end
      wait_ready();
      access(0, 0, 1, 16'h0003, 8'h00);
      access(1, 1, 1, 16'h0000, 8'h00);
      n_cmp++;
      if (vld_w[1] !== 1'b0) begin
         n_fail++; $display("FAIL flush_lat2: got %b want 0", vld_w[1]);
      end
      access(1, 0, 1, 16'h0003, 8'h00);
      access(0, 1, 1, 16'h0000, 8'h00);
      n_cmp++;
      if (vld_w !== 4'h0) begin
         n_fail++; $display("FAIL read_in_reset: got %b want 0000", vld_w);
      end
      wait_ready();
   endtask

   task automatic test_random();
      logic [15:0] a;
      for (int k = 0; k < 800; k++) begin
         a = 16'(($urandom_range(0, 31) << 11) | $urandom_range(0, 31));
         access(0, ($urandom_range(0, 3) == 0), 1'($urandom), a, 8'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_clear_sweep();
      test_mirror();
      test_latency();
      test_rom();
      test_reset_mid();
      test_random();
      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run exceeded time limit at cyc %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mirrored_ram.md
MIRRORED_RAM -- requirements
Module: mirrored_ram

Interface
REQ-001 SHALL have parameter ADDR_W, 16, CPU bus address width.
REQ-002 SHALL have parameter DEPTH_LOG2, 11, log2 of physical depth; 2048 bytes by default, NES internal RAM.
REQ-003 SHALL have parameter DATA_W, 8, data width.
REQ-004 SHALL have parameter READ_LAT, 1, read latency in cycles; only 1 or 2 are legal.
REQ-005 SHALL have parameter ROM_MODE, 0, when 1 all writes are ignored.
REQ-006 SHALL have parameter CLEAR_ON_RESET, 1, when 1 the whole array is filled after reset.
REQ-007 SHALL have parameter FILL_VALUE, 0, byte written by the clear sweep.
REQ-008 SHALL have port clk  input  1  the single clock; all logic updates on posedge clk.
REQ-009 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-010 SHALL have port addr  input  ADDR_W  bus address.
REQ-011 SHALL have port data  inout  DATA_W  bidirectional bus; Hi-Z when not driving.
REQ-012 SHALL have port rw_n  input  1  1 = read, 0 = write.
REQ-013 SHALL have port cs_n  input  1  active-low chip select.
REQ-014 SHALL have port ready  output  1  high when accesses are accepted.
REQ-015 SHALL have port rd_valid  output  1  one-cycle pulse when read data is valid on data.

Function
REQ-016 SHALL form the physical index as addr[DEPTH_LOG2-1:0], so upper address bits mirror; with the default, 0x0800, 0x1000 and 0x1800 alias 0x0000.
REQ-017 SHALL implement two FSM states:
- CLEAR: ready=0; writes FILL_VALUE to clr_idx each cycle; clr_idx increments from 0.
- IDLE: ready=1.
REQ-018 SHALL leave CLEAR for IDLE on the cycle after clr_idx = 2^DEPTH_LOG2-1 is written; clr_idx SHALL NOT wrap and restart.
REQ-019 SHALL treat a cycle with state IDLE, cs_n=0 and rw_n=0 as a write: mem[idx] <= data at that edge, unless ROM_MODE=1, in which case the array is unchanged and no error is raised.
REQ-020 SHALL treat a cycle with state IDLE, cs_n=0 and rw_n=1 as a read: mem[idx] is captured into stage 1 at that edge.
REQ-021 SHALL, for READ_LAT=2, copy stage 1 into stage 2 at the next edge; the output register is the last stage.
REQ-022 SHALL pulse rd_valid high for exactly one cycle, READ_LAT cycles after the accepting edge; back-to-back reads SHALL give one pulse per read, with full throughput of one read per cycle.
REQ-023 SHALL drive data from the output register only when cs_n=0 && rw_n=1 && ready=1; otherwise data SHALL be Hi-Z.
REQ-024 SHALL ignore accesses (no write, no read capture, no rd_valid) while state is CLEAR or rst=1.
REQ-025 SHALL return, for a read in the cycle after a write to the same index, the newly written value.
REQ-026 SHALL flush the read pipeline when rst is asserted while a read is in flight; no rd_valid SHALL follow.

Reset
REQ-027 SHALL, while rst=1 at an edge, set: rd_valid=0, output and pipeline registers=0, clr_idx=0, and state=CLEAR if CLEAR_ON_RESET=1, else IDLE.
REQ-028 SHALL restart the sweep from index 0 when rst is asserted mid-CLEAR.
REQ-029 SHALL NOT reset array contents except by the CLEAR sweep.
REQ-030 SHALL make ready combinational from state; with CLEAR_ON_RESET=0, ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-031 SHALL place the FSM state encoding (CLEAR, IDLE) and the legal READ_LAT values in the shared package mem_pkg.
REQ-032 SHALL instantiate one sub-module, ram_sp_core: single-port synchronous array with write enable and registered read, parametrised by DEPTH_LOG2 and DATA_W; the sweep and bus logic SHALL mux into its port.
REQ-033 SHALL size the RTL at roughly 150-250 lines in total.

Verification
REQ-034 SHALL cover clear sweep: defaults, pulse rst for 1 cycle -> ready=0 for exactly 2048 cycles, then 1; reads of 0x0000, 0x03FF and 0x07FF return 0x00.
REQ-035 SHALL cover mirroring: write 0xA5 to 0x0012, read 0x1812 -> data=0xA5 with rd_valid one cycle after acceptance.
REQ-036 SHALL cover latency: READ_LAT=2, reads to 0x0001, 0x0002, 0x0003 on consecutive cycles, values 0x11, 0x22, 0x33 -> rd_valid high for 3 consecutive cycles starting 2 cycles after the first read, data 0x11, 0x22, 0x33.
REQ-037 SHALL cover ROM mode: ROM_MODE=1, write 0xFF to 0x0005, read 0x0005 -> FILL_VALUE returned.
REQ-038 SHALL cover reset mid-operation: assert rst at sweep index 1000 -> ready stays 0 for a further 2048 cycles after release; assert rst during a read in flight -> no rd_valid.
REQ-039 SHALL cover bus release: cs_n=1, or rw_n=0, or state CLEAR -> data is Hi-Z, checked each cycle.
